// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per cycle.
// Operands are reduced to magnitudes at accept time; the sign is reapplied in FIXUP.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic              sign_q, sign_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              a_signed, b_signed, a_neg, b_neg, sign_in;
  logic              div_zero, sgn_ovf, fast;
  logic [XLEN-1:0]   a_mag, b_mag, fast_res;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_fix, fix_res;

  function automatic logic [XLEN-1:0] cond_neg(input logic neg, input logic [XLEN-1:0] v);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cond_neg2(input logic neg, input logic [2*XLEN-1:0] v);
    return neg ? -v : v;
  endfunction

  // Accept-time decode: operand signedness, magnitudes, result sign, fast-path detection
  always_comb begin
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg    = a_signed && rs1_data[XLEN-1];
    b_neg    = b_signed && rs2_data[XLEN-1];
    a_mag    = cond_neg(a_neg, rs1_data);
    b_mag    = cond_neg(b_neg, rs2_data);
    sign_in  = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
    div_zero = funct3[2] && (rs2_data == '0);
    sgn_ovf  = funct3[2] && !funct3[0] && (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
    fast     = div_zero || sgn_ovf;
    if (div_zero) fast_res = funct3[1] ? rs1_data : '1;
    else          fast_res = funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // Iteration datapath: multiplier/quotient lives in lo_q, partial product/remainder in hi_q
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    prod_fix  = cond_neg2(sign_q, {hi_q, lo_q});
    div_fix   = cond_neg(sign_q, funct3_q[1] ? hi_q : lo_q);
    if (funct3_q[2])               fix_res = div_fix;
    else if (funct3_q[1:0] == 2'b00) fix_res = prod_fix[XLEN-1:0];
    else                           fix_res = prod_fix[2*XLEN-1:XLEN];
  end

  always_comb begin
    state_d  = state_q;
    funct3_d = funct3_q;
    sign_d   = sign_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    result_d = result_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start && !(flush && state_q == S_DONE)) begin
          funct3_d = funct3;
          sign_d   = sign_in;
          cnt_d    = '0;
          hi_d     = '0;
          lo_d     = funct3[2] ? a_mag : b_mag;
          opb_d    = funct3[2] ? b_mag : a_mag;
          if (fast) begin
            result_d = fast_res;
            state_d  = S_DONE;
          end else begin
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 5'd1;
          if (funct3_q[2]) begin
            if (!div_diff[XLEN]) begin
              hi_d = div_diff[XLEN-1:0];
              lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
              hi_d = div_shift[XLEN-1:0];
              lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
          end else begin
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
          end
          if (cnt_q == 5'd31) state_d = S_FIXUP;
        end
      end
      S_FIXUP: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          result_d = fix_res;
          state_d  = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      funct3_q <= '0;
      sign_q   <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      funct3_q <= funct3_d;
      sign_q   <= sign_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == S_CALC) || (state_q == S_FIXUP);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized ops
// compared against a plain-arithmetic RV32M reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] rs1_data, rs2_data;
  logic        busy, done;
  logic [31:0] result;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_res;
  int          exp_lat, exp_busy;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, q;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (f3)
      3'b000: begin p = ua * ub; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * ub; return p[63:32]; end
      3'b011: begin p = ua * ub; return p[63:32]; end
      3'b100: begin
        if (b == 32'h0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        q = sa / sb; return q[31:0];
      end
      3'b101: return (b == 32'h0) ? 32'hFFFFFFFF : a / b;
      3'b110: begin
        if (b == 32'h0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        q = sa % sb; return q[31:0];
      end
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic fast;
    start    = 1'b1;
    funct3   = f3;
    rs1_data = a;
    rs2_data = b;
    exp_res  = ref_model(f3, a, b);
    fast     = f3[2] && (b == 32'h0 || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
    exp_lat  = fast ? 1 : 34;
    exp_busy = fast ? 0 : 33;
  endtask

  // Operands are scrambled right after acceptance; the result must not depend on them.
  task automatic wait_done(input string tag);
    int lat;
    int bc;
    lat = 0;
    bc  = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start    = 1'b0;
        funct3   = 3'($urandom);
        rs1_data = $urandom;
        rs2_data = $urandom;
      end
      if (busy) bc++;
      if (done) begin
        lat = c;
        break;
      end
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " busy cycles"}, 32'(bc), 32'(exp_busy));
    chk({tag, " result"}, result, exp_res);
  endtask

  task automatic run(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input string tag);
    @(negedge clk);
    issue(f3, a, b);
    wait_done(tag);
    @(negedge clk);
    chk({tag, " done pulse"}, 32'(done), 32'h0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] keep;
    int dc;
    logic [2:0] f3;
    logic [31:0] a, b;
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    funct3 = 3'b0; rs1_data = 32'h0; rs2_data = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset done", 32'(done), 32'h0);
    chk("reset result", result, 32'h0);
    rst = 1'b0;

    run(3'b000, 32'd7, 32'hFFFFFFFD, "mul");

    // Reset in the middle of CALC
    @(negedge clk);
    issue(3'b000, 32'd5, 32'd9);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset busy", 32'(busy), 32'h0);
    chk("midreset done", 32'(done), 32'h0);
    chk("midreset result", result, 32'h0);
    run(3'b000, 32'd5, 32'd9, "mul after reset");

    run(3'b001, 32'h80000000, 32'h80000000, "mulh");
    run(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhu");
    run(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu");
    run(3'b100, 32'hFFFFFFF9, 32'd2, "div neg");
    run(3'b110, 32'hFFFFFFF9, 32'd2, "rem neg");
    run(3'b101, 32'd100, 32'd7, "divu");
    run(3'b110, 32'h00001234, 32'h0, "rem by zero");
    run(3'b100, 32'h80000000, 32'hFFFFFFFF, "div ovf");
    run(3'b110, 32'h80000000, 32'hFFFFFFFF, "rem ovf");

    // Back-to-back: fast op chained into a normal op from DONE
    @(negedge clk);
    issue(3'b101, 32'h00001234, 32'h0);
    wait_done("divu by zero");
    issue(3'b011, 32'h12345678, 32'h9ABCDEF0);
    wait_done("chained mulhu");
    issue(3'b111, 32'd100, 32'd7);
    wait_done("chained remu");
    @(negedge clk);
    chk("chain done pulse", 32'(done), 32'h0);

    // Flush at CALC cycle 5 with a simultaneous (ignored) start
    keep = result;
    @(negedge clk);
    issue(3'b100, 32'd1000, 32'd3);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    flush = 1'b1; start = 1'b1; funct3 = 3'b101; rs1_data = 32'h55; rs2_data = 32'h0;
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    chk("flush busy", 32'(busy), 32'h0);
    chk("flush done", 32'(done), 32'h0);
    chk("flush result", result, keep);
    dc = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dc++;
    end
    chk("flush no done", 32'(dc), 32'h0);

    // Randomized ops, some chained directly from DONE
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom % 8)
        0: b = 32'h0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'd1 + ($urandom % 16);
        3: a = $urandom % 1000;
        default: ;
      endcase
      issue(f3, a, b);
      wait_done($sformatf("rand%0d f3=%0d", i, f3));
      if ($urandom % 2 == 0) begin
        @(negedge clk);
        chk($sformatf("rand%0d done pulse", i), 32'(done), 32'h0);
      end
    end
    @(negedge clk);
    start = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
